// File: rtl/cmd_interp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_interp_ctrl_pkg
// Description : Shared definitions for the calculator command interpreter:
//               opcode byte values, ALU operation encodings, FSM state
//               encoding and the opcode decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_interp_ctrl_pkg;

    // ASCII operator characters received over the UART
    localparam logic [7:0] OPC_ADD = 8'h2B;  // '+'
    localparam logic [7:0] OPC_SUB = 8'h2D;  // '-'
    localparam logic [7:0] OPC_MUL = 8'h2A;  // '*'
    localparam logic [7:0] OPC_AND = 8'h26;  // '&'

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_AND = 2'd3
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_LOAD_A   = 3'd2,
        ST_GET_B    = 3'd3,
        ST_LOAD_B   = 3'd4,
        ST_START    = 3'd5,
        ST_WAIT_ALU = 3'd6,
        ST_SEND     = 3'd7
    } state_t;

    typedef struct packed {
        logic    valid;
        alu_op_t op;
    } opc_dec_t;

    // Map an opcode byte onto an ALU operation; valid=0 for unknown bytes
    function automatic opc_dec_t decode_opcode(input logic [7:0] byte_in);
        opc_dec_t dec;
        dec.valid = 1'b1;
        dec.op    = ALU_ADD;
        case (byte_in)
            OPC_ADD: dec.op = ALU_ADD;
            OPC_SUB: dec.op = ALU_SUB;
            OPC_MUL: dec.op = ALU_MUL;
            OPC_AND: dec.op = ALU_AND;
            default: dec.valid = 1'b0;
        endcase
        return dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_interp_ctrl_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : cmd_timeout_cnt
// Description : Inter-byte idle counter. Clears on request, counts while
//               enabled and flags expiry on the last allowed idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Idle counter: clear has priority; holds at the last value so it never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/cmd_interp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cmd_interp_ctrl
// Description : Command sequencing FSM. Parses opcode / operand A / operand B
//               bytes, loads the operand register, starts the ALU, waits for
//               completion and requests result transmission.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_interp_ctrl
    import cmd_interp_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] reg_in,
    output logic       load1,
    output logic       load2,
    output logic [1:0] alu_op,
    output logic       alu_start,
    input  logic       alu_done,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic       busy,
    output logic       err
);

    state_t     r_state;
    logic [7:0] r_reg_in;
    alu_op_t    r_alu_op;
    logic       r_load1;
    logic       r_load2;
    logic       r_alu_start;
    logic       r_tx_start;
    logic       r_busy;
    logic       r_err;

    opc_dec_t   w_dec;
    logic       w_in_get;
    logic       w_expired;

    assign w_dec    = decode_opcode(rx_data);
    assign w_in_get = (r_state == ST_GET_A) || (r_state == ST_GET_B);

    // Counter is held clear outside the operand-wait states, so it starts at
    // zero on every entry, and restarts on each accepted byte.
    cmd_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_in_get || rx_valid),
        .enable  (w_in_get),
        .expired (w_expired)
    );

    // Command FSM with all outputs registered; strobes default low each cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_reg_in    <= 8'h00;
            r_alu_op    <= ALU_ADD;
            r_load1     <= 1'b0;
            r_load2     <= 1'b0;
            r_alu_start <= 1'b0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_load1     <= 1'b0;
            r_load2     <= 1'b0;
            r_alu_start <= 1'b0;
            r_tx_start  <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (w_dec.valid) begin
                            r_alu_op <= w_dec.op;
                            r_state  <= ST_GET_A;
                            r_busy   <= 1'b1;
                        end else begin
                            r_err    <= 1'b1;
                        end
                    end
                end
                ST_GET_A: begin
                    // A byte on the expiry cycle still wins over the timeout
                    if (rx_valid) begin
                        r_reg_in <= rx_data;
                        r_load1  <= 1'b1;
                        r_state  <= ST_LOAD_A;
                    end else if (w_expired) begin
                        r_err    <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                ST_LOAD_A: begin
                    r_state <= ST_GET_B;
                end
                ST_GET_B: begin
                    if (rx_valid) begin
                        r_reg_in <= rx_data;
                        r_load2  <= 1'b1;
                        r_state  <= ST_LOAD_B;
                    end else if (w_expired) begin
                        r_err    <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                ST_LOAD_B: begin
                    r_alu_start <= 1'b1;
                    r_state     <= ST_START;
                end
                ST_START: begin
                    r_state <= ST_WAIT_ALU;
                end
                ST_WAIT_ALU: begin
                    if (alu_done) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_in    = r_reg_in;
    assign load1     = r_load1;
    assign load2     = r_load2;
    assign alu_op    = r_alu_op;
    assign alu_start = r_alu_start;
    assign tx_start  = r_tx_start;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cmd_interp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_interp_ctrl
// Description : Directed self-checking bench for cmd_interp_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cmd_interp_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       alu_done = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] reg_in;
    logic       load1, load2, alu_start, tx_start, busy, err;
    logic [1:0] alu_op;

    int errors = 0;
    int checks = 0;

    // pulse monitor state
    int n_load1 = 0, n_load2 = 0, n_start = 0, n_tx = 0, n_err = 0, n_overlap = 0;
    logic [7:0] cap_a = 8'h00, cap_b = 8'h00;
    int s_load1, s_load2, s_start, s_tx, s_err;

    cmd_interp_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .reg_in    (reg_in),
        .load1     (load1),
        .load2     (load2),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Count strobes and capture the operand bus on each load pulse
    always @(negedge clk) begin
        if ((int'(load1) + int'(load2) + int'(alu_start) + int'(tx_start) + int'(err)) > 1)
            n_overlap++;
        if (load1)     begin n_load1++; cap_a = reg_in; end
        if (load2)     begin n_load2++; cap_b = reg_in; end
        if (alu_start) n_start++;
        if (tx_start)  n_tx++;
        if (err)       n_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic snap();
        s_load1 = n_load1; s_load2 = n_load2; s_start = n_start;
        s_tx = n_tx; s_err = n_err;
    endtask

    // Opcode/A/B with 3-cycle strobe spacing; returns with the FSM in WAIT_ALU
    task automatic do_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send(op); idle(2);
        send(a);  idle(2);
        send(b);  idle(2);
    endtask

    // ALU completion then tx_busy held for nbusy cycles; returns in the tx_start cycle
    task automatic finish_cmd(input int nbusy);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tx_busy  = (nbusy > 0);
        idle(nbusy);
        tx_busy  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if ({reg_in, alu_op, load1, load2, alu_start, tx_start, err, busy} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got reg_in=%h alu_op=%0d l1=%b l2=%b st=%b tx=%b err=%b busy=%b, expected all 0",
                     reg_in, alu_op, load1, load2, alu_start, tx_start, err, busy);
        end
        rst = 1'b1;
        idle(2);
        checks++;
        if ({busy, err} !== 2'b00) begin
            errors++; $display("FAIL reset_release: busy/err=%b expected 00", {busy, err});
        end
    endtask

    task automatic test_nominal();
        snap();
        send(8'h2B);
        checks++;
        if ({busy, alu_op} !== 3'b1_00) begin
            errors++; $display("FAIL nom_opcode: busy,alu_op=%b expected 100", {busy, alu_op});
        end
        idle(2);
        send(8'h05);
        checks++;
        if ({load1, reg_in} !== {1'b1, 8'h05}) begin
            errors++; $display("FAIL nom_load1: load1=%b reg_in=%h expected 1/05", load1, reg_in);
        end
        tick();
        checks++;
        if ({load1, reg_in} !== {1'b0, 8'h05}) begin
            errors++; $display("FAIL nom_load1_width: load1=%b reg_in=%h expected 0/05", load1, reg_in);
        end
        idle(1);
        send(8'h03);
        checks++;
        if ({load2, alu_start, reg_in} !== {2'b10, 8'h03}) begin
            errors++; $display("FAIL nom_load2: load2=%b alu_start=%b reg_in=%h expected 1/0/03", load2, alu_start, reg_in);
        end
        tick();
        checks++;
        if ({load2, alu_start} !== 2'b01) begin
            errors++; $display("FAIL nom_alu_start: load2=%b alu_start=%b expected 0/1", load2, alu_start);
        end
        idle(4);
        checks++;
        if ({busy, alu_start, n_tx - s_tx} !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL nom_wait_alu: busy=%b alu_start=%b tx_pulses=%0d expected 1/0/0", busy, alu_start, n_tx - s_tx);
        end
        finish_cmd(0);
        checks++;
        if ({tx_start, busy} !== 2'b10) begin
            errors++; $display("FAIL nom_tx_start: tx_start=%b busy=%b expected 1/0", tx_start, busy);
        end
        tick();
        checks++;
        if ({n_load1 - s_load1, n_load2 - s_load2, n_start - s_start, n_tx - s_tx} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            errors++; $display("FAIL nom_pulse_counts: l1=%0d l2=%0d st=%0d tx=%0d expected 1 each",
                               n_load1 - s_load1, n_load2 - s_load2, n_start - s_start, n_tx - s_tx);
        end
    endtask

    task automatic test_bad_opcode();
        snap();
        send(8'h41);
        checks++;
        if ({err, busy, load1} !== 3'b100) begin
            errors++; $display("FAIL bad_op_err: err=%b busy=%b load1=%b expected 1/0/0", err, busy, load1);
        end
        tick();
        checks++;
        if ({err, busy, n_err - s_err, n_load1 - s_load1} !== {2'b00, 32'd1, 32'd0}) begin
            errors++; $display("FAIL bad_op_single: err=%b busy=%b errs=%0d loads=%0d expected 0/0/1/0",
                               err, busy, n_err - s_err, n_load1 - s_load1);
        end
        do_cmd(8'h2D, 8'h10, 8'h01);
        checks++;
        if ({alu_op, cap_a, cap_b} !== {2'd1, 8'h10, 8'h01}) begin
            errors++; $display("FAIL bad_op_recover: alu_op=%0d a=%h b=%h expected 1/10/01", alu_op, cap_a, cap_b);
        end
        finish_cmd(0);
        checks++;
        if (tx_start !== 1'b1) begin
            errors++; $display("FAIL bad_op_tx: tx_start=%b expected 1", tx_start);
        end
    endtask

    task automatic test_timeout();
        snap();
        send(8'h2A);
        checks++;
        if (alu_op !== 2'd2) begin
            errors++; $display("FAIL to_alu_op: alu_op=%0d expected 2", alu_op);
        end
        idle(2);
        send(8'h07);
        idle(TO);
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++; $display("FAIL to_early: err=%b busy=%b expected 0/1", err, busy);
        end
        tick();
        checks++;
        if ({err, busy, reg_in} !== {2'b10, 8'h07}) begin
            errors++; $display("FAIL to_expire: err=%b busy=%b reg_in=%h expected 1/0/07", err, busy, reg_in);
        end
        tick();
        checks++;
        if ({err, n_load2 - s_load2, n_err - s_err} !== {1'b0, 32'd0, 32'd1}) begin
            errors++; $display("FAIL to_single: err=%b load2s=%0d errs=%0d expected 0/0/1", err, n_load2 - s_load2, n_err - s_err);
        end
        // byte arriving on the last allowed cycle beats the timeout
        snap();
        send(8'h2B); idle(2);
        send(8'h33); idle(TO);
        send(8'h44);
        checks++;
        if ({err, load2, reg_in} !== {2'b01, 8'h44}) begin
            errors++; $display("FAIL to_byte_wins: err=%b load2=%b reg_in=%h expected 0/1/44", err, load2, reg_in);
        end
        idle(2);
        finish_cmd(0);
        checks++;
        if ({tx_start, n_err - s_err, cap_a, cap_b} !== {1'b1, 32'd0, 8'h33, 8'h44}) begin
            errors++; $display("FAIL to_clean_cmd: tx=%b errs=%0d a=%h b=%h expected 1/0/33/44",
                               tx_start, n_err - s_err, cap_a, cap_b);
        end
    endtask

    task automatic test_tx_busy();
        do_cmd(8'h2A, 8'h03, 8'h04);
        snap();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tx_busy  = 1'b1;
        idle(10);
        checks++;
        if ({busy, tx_start, n_tx - s_tx} !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL txb_hold: busy=%b tx_start=%b tx_pulses=%0d expected 1/0/0", busy, tx_start, n_tx - s_tx);
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if ({tx_start, busy} !== 2'b10) begin
            errors++; $display("FAIL txb_start: tx_start=%b busy=%b expected 1/0", tx_start, busy);
        end
        idle(3);
        checks++;
        if ({tx_start, n_tx - s_tx} !== {1'b0, 32'd1}) begin
            errors++; $display("FAIL txb_once: tx_start=%b tx_pulses=%0d expected 0/1", tx_start, n_tx - s_tx);
        end
    endtask

    task automatic test_drop_byte();
        do_cmd(8'h2B, 8'h11, 8'h22);
        snap();
        send(8'h99);
        checks++;
        if ({reg_in, err, busy} !== {8'h22, 2'b01}) begin
            errors++; $display("FAIL drop_reg: reg_in=%h err=%b busy=%b expected 22/0/1", reg_in, err, busy);
        end
        idle(2);
        checks++;
        if ({n_load1 - s_load1, n_load2 - s_load2, n_err - s_err} !== {32'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL drop_pulses: l1=%0d l2=%0d errs=%0d expected 0/0/0",
                               n_load1 - s_load1, n_load2 - s_load2, n_err - s_err);
        end
        finish_cmd(0);
        checks++;
        if (tx_start !== 1'b1) begin
            errors++; $display("FAIL drop_tx: tx_start=%b expected 1", tx_start);
        end
        // alu_done while idle must not wake the FSM
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        idle(2);
        checks++;
        if ({busy, tx_start} !== 2'b00) begin
            errors++; $display("FAIL stray_done: busy=%b tx_start=%b expected 0/0", busy, tx_start);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h2D); idle(2);
        send(8'h22);
        tick();
        checks++;
        if ({busy, reg_in} !== {1'b1, 8'h22}) begin
            errors++; $display("FAIL rstm_pre: busy=%b reg_in=%h expected 1/22", busy, reg_in);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({reg_in, alu_op, load1, load2, alu_start, tx_start, err, busy} !== 16'h0) begin
            errors++; $display("FAIL rstm_async: reg_in=%h alu_op=%0d l1=%b l2=%b st=%b tx=%b err=%b busy=%b expected all 0",
                               reg_in, alu_op, load1, load2, alu_start, tx_start, err, busy);
        end
        snap();
        tick();
        rst = 1'b1;
        idle(2);
        checks++;
        if ({busy, n_load2 - s_load2} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL rstm_release: busy=%b load2s=%0d expected 0/0", busy, n_load2 - s_load2);
        end
        do_cmd(8'h26, 8'h0F, 8'hF0);
        checks++;
        if ({alu_op, cap_a, cap_b, n_load1 - s_load1} !== {2'd3, 8'h0F, 8'hF0, 32'd1}) begin
            errors++; $display("FAIL rstm_next_cmd: alu_op=%0d a=%h b=%h l1=%0d expected 3/0F/F0/1",
                               alu_op, cap_a, cap_b, n_load1 - s_load1);
        end
        finish_cmd(0);
        checks++;
        if ({tx_start, busy} !== 2'b10) begin
            errors++; $display("FAIL rstm_tx: tx_start=%b busy=%b expected 1/0", tx_start, busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_opcode();
        test_timeout();
        test_tx_busy();
        test_drop_byte();
        test_reset_mid();
        idle(2);
        checks++;
        if (n_overlap !== 0) begin
            errors++; $display("FAIL strobe_exclusive: overlap cycles=%0d expected 0", n_overlap);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on run time in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cmd_interp_ctrl.md
Name: cmd_interp_ctrl

Overview:
Command-sequencing FSM for the calculator command interpreter. It parses a 3-byte command stream (opcode, operand A, operand B) from the UART receive side and drives the two-operand output register through its in/load1/load2 interface. It then starts the ALU, waits for completion and triggers result transmission. It sits between the UART RX byte strobe and the operand register / ALU / UART TX.

Parameters:
TIMEOUT_CYCLES, 1000, max idle clocks allowed between command bytes before abort (>=2)
CNT_W, 10, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
rx_data  in  8  received byte, valid only with rx_valid
rx_valid  in  1  single-cycle strobe, one byte per strobe
reg_in  out  8  data bus to operand register
load1  out  1  one-cycle pulse: operand register captures reg_in into operand A
load2  out  1  one-cycle pulse: operand register captures reg_in into operand B
alu_op  out  2  operation code: 0 add, 1 sub, 2 mul, 3 and
alu_start  out  1  one-cycle pulse starting ALU
alu_done  in  1  ALU completion strobe (level or pulse accepted)
tx_busy  in  1  UART TX busy
tx_start  out  1  one-cycle pulse requesting result transmission
busy  out  1  high whenever state != IDLE
err  out  1  one-cycle pulse on bad opcode or timeout

Behaviour:
- Reset (rst=0, async): state=IDLE; reg_in=0; alu_op=0; counter=0. load1, load2, alu_start, tx_start, err and busy all 0. Outputs stay there until rst deasserts.
- Opcode map: 0x2B->0, 0x2D->1, 0x2A->2, 0x26->3. Any other byte is an invalid opcode.
- IDLE: rx_valid with a valid opcode -> alu_op latched, go to GET_A. rx_valid with an invalid opcode -> err pulse next cycle, stay IDLE.
- GET_A: rx_valid -> reg_in<=rx_data, go to LOAD_A.
- LOAD_A: load1=1 for exactly this cycle, with reg_in stable. Next state is GET_B.
- GET_B: rx_valid -> reg_in<=rx_data, go to LOAD_B.
- LOAD_B: load2=1 for exactly this cycle. Next state is START.
- START: alu_start=1 for one cycle. Next state is WAIT_ALU.
- WAIT_ALU: stays until alu_done=1, then go to SEND.
- SEND: waits while tx_busy=1. First cycle with tx_busy=0 -> tx_start=1 for that cycle, go to IDLE.
- Latency, measured from the operand-B strobe edge: load2 at +1, alu_start at +2. load1 follows the operand-A strobe by 1 cycle.
- Timeout: counter clears on entry to GET_A/GET_B and on each accepted byte, and increments each cycle in GET_A/GET_B. When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid: err pulse, go to IDLE, reg_in unchanged. If rx_valid arrives in the same cycle as the timeout, the byte wins and no error is raised.
- rx_valid in LOAD_A, LOAD_B, START, WAIT_ALU or SEND is ignored: the byte is dropped, there is no error, and the state is unaffected.
- alu_op holds from opcode acceptance until the next valid opcode. It is not cleared on return to IDLE.
- load1, load2, alu_start, tx_start and err are registered outputs and are never high simultaneously.
- alu_done outside WAIT_ALU is ignored.
- Reset asserted mid-command aborts immediately to reset values. No partial loads complete after reset.

Decomposition:
- Shared package/header (calc_defs): opcode byte constants (OPC_ADD=8'h2B, OPC_SUB=8'h2D, OPC_MUL=8'h2A, OPC_AND=8'h26), 2-bit ALU op encodings, FSM state encoding (8 states, 3-bit).
- One natural sub-module: cmd_timeout_cnt (clear/enable/expire counter parameterised by TIMEOUT_CYCLES, CNT_W). All other logic lives in a single FSM module.

Test Plan:
- Bytes 0x2B, 0x05, 0x03 spaced 3 cycles -> alu_op=0; load1 pulse with reg_in=0x05; load2 pulse with reg_in=0x03; alu_start 2 cycles after the 0x03 strobe. Then alu_done=1 -> tx_start one cycle later with tx_busy=0, busy falls.
- Opcode 0x41 -> err single pulse, busy stays 0, no load pulses. A following 0x2D,0x10,0x01 still completes with alu_op=1.
- 0x2A, 0x07, then silence for TIMEOUT_CYCLES=16 -> err pulse after 16 cycles in GET_B, load2 never pulses, busy=0. Next command starts cleanly.
- Full command with tx_busy held high 10 cycles after alu_done -> tx_start only on first cycle tx_busy=0, exactly one pulse.
- Extra byte 0x99 injected during WAIT_ALU -> ignored: reg_in unchanged, no load pulse, no err.
- rst driven low while in GET_B after operand A 0x22 loaded -> all outputs immediately at reset values. After release, busy=0 and the next 0x26,0x0F,0xF0 sequence behaves normally.
